// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings and the fixed oversampling ratio.
// Used by uart_rx_frame now and by uart_tx_frame later.
package uart_pkg;

  localparam int OVERSAMPLE = 16;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;
  localparam logic [2:0] ST_BREAK  = 3'd5;

  typedef enum logic [2:0] {
    IDLE   = ST_IDLE,
    START  = ST_START,
    DATA   = ST_DATA,
    PARITY = ST_PARITY,
    STOP   = ST_STOP,
    BREAK  = ST_BREAK
  } uart_state_e;

endpackage

// File: rtl/uart_rx_frame_if.sv
// Receive-side signal bundle between the serial line / CPU consumer and uart_rx_frame.
// master = line driver and byte consumer, slave = the receiver.
interface uart_rx_frame_if;

  logic       uart_rx;
  logic       rx_ack;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic       rx_busy;

  modport master (
    output uart_rx, rx_ack,
    input  rx_data, rx_valid, frame_err, overrun, rx_busy
  );

  modport slave (
    input  uart_rx, rx_ack,
    output rx_data, rx_valid, frame_err, overrun, rx_busy
  );

endinterface

// File: rtl/uart_baud_tick.sv
// Oversampling tick generator: one-cycle tick every DIV sysclk cycles.
// Free-running; restart realigns the phase to the detected start edge.
module uart_baud_tick #(
  parameter int DIV = 651
) (
  input  logic sysclk,
  input  logic reset,
  input  logic restart,
  output logic tick
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

  logic [CNT_W-1:0] cnt;

  // Divide counter, wraps at DIV-1 and is forced to 0 on restart
  always_ff @(posedge sysclk) begin
    if (reset || restart) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_rx_frame.sv
// UART receive front end: pin synchroniser, 16x oversampling with 3-sample
// majority vote, 8-bit LSB-first deframer and a single-byte holding register
// with valid / frame-error / overrun status cleared by rx_ack.
// Optional parity bit enabled by defining UART_RX_PARITY_EN (PARITY_ODD selects odd).
module uart_rx_frame #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int OVERSAMPLE = uart_pkg::OVERSAMPLE,
  parameter int PARITY_ODD = 0
) (
  input logic            sysclk,
  input logic            reset,
  uart_rx_frame_if.slave rx_if
);

  import uart_pkg::*;

  // Nearest-integer divide; the per-bit tick counter below is 4 bits, so OVERSAMPLE is 16
  localparam int DIV = (CLK_HZ + (BAUD * OVERSAMPLE) / 2) / (BAUD * OVERSAMPLE);

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  logic        sync1;
  logic        rxs;
  logic        rxs_d;
  logic        tick;
  logic        restart;

  uart_state_e state;
  uart_state_e state_d;
  logic [3:0]  s_cnt;
  logic [3:0]  s_d;
  logic [2:0]  idx;
  logic [2:0]  idx_d;

  logic        vote7;
  logic        vote8;
  logic        bit_now;
  logic [7:0]  shift;
  logic        shift_en;
  logic        load_d;
  logic        load_p1;
  logic        ferr_set;
  logic        parity_ok;

  logic [7:0]  rx_data_q;
  logic        rx_valid_q;
  logic        frame_err_q;
  logic        overrun_q;
  logic        rx_busy_q;

  // Two-flop synchroniser plus one delay flop for falling-edge detection (all idle high)
  always_ff @(posedge sysclk) begin
    if (reset) begin
      sync1 <= 1'b1;
      rxs   <= 1'b1;
      rxs_d <= 1'b1;
    end else begin
      sync1 <= rx_if.uart_rx;
      rxs   <= sync1;
      rxs_d <= rxs;
    end
  end

  uart_baud_tick #(
    .DIV (DIV)
  ) u_tick (
    .sysclk  (sysclk),
    .reset   (reset),
    .restart (restart),
    .tick    (tick)
  );

  assign bit_now = maj3(vote7, vote8, rxs);

`ifdef UART_RX_PARITY_EN
  localparam logic PARITY_BIT = (PARITY_ODD != 0);
  localparam uart_state_e AFTER_DATA = PARITY;
  logic par_store;
`else
  localparam uart_state_e AFTER_DATA = STOP;
`endif

  // FSM next-state and per-bit control decisions
  always_comb begin
    state_d  = state;
    s_d      = s_cnt;
    idx_d    = idx;
    restart  = 1'b0;
    shift_en = 1'b0;
    load_d   = 1'b0;
    ferr_set = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_store = 1'b0;
`endif
    if (tick) begin
      s_d = s_cnt + 4'd1;
    end
    case (state)
      IDLE: begin
        s_d   = 4'd0;
        idx_d = 3'd0;
        // Only a genuine 1->0 transition arms the receiver
        if (rxs_d && !rxs) begin
          state_d = START;
          restart = 1'b1;
        end
      end
      START: begin
        if (tick && s_cnt == 4'd9 && bit_now) begin
          state_d = IDLE;
        end else if (tick && s_cnt == 4'd15) begin
          state_d = DATA;
          idx_d   = 3'd0;
        end
      end
      DATA: begin
        if (tick && s_cnt == 4'd9) begin
          shift_en = 1'b1;
        end
        if (tick && s_cnt == 4'd15) begin
          if (idx == 3'd7) begin
            state_d = AFTER_DATA;
          end else begin
            idx_d = idx + 3'd1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick && s_cnt == 4'd9) begin
          par_store = 1'b1;
        end
        if (tick && s_cnt == 4'd15) begin
          state_d = STOP;
        end
      end
`endif
      STOP: begin
        if (tick && s_cnt == 4'd9) begin
          if (!bit_now) begin
            ferr_set = 1'b1;
            state_d  = BREAK;
          end else if (!parity_ok) begin
            ferr_set = 1'b1;
            state_d  = IDLE;
          end else begin
            load_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      BREAK: begin
        s_d = 4'd0;
        if (rxs) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // FSM state, tick/bit counters, deferred load request and busy flag
  always_ff @(posedge sysclk) begin
    if (reset) begin
      state     <= IDLE;
      s_cnt     <= 4'd0;
      idx       <= 3'd0;
      load_p1   <= 1'b0;
      rx_busy_q <= 1'b0;
    end else begin
      state     <= state_d;
      s_cnt     <= s_d;
      idx       <= idx_d;
      load_p1   <= load_d;
      rx_busy_q <= (state_d != IDLE);
    end
  end

  // Vote samples at ticks 7 and 8, and the LSB-first shift register
  always_ff @(posedge sysclk) begin
    if (tick && s_cnt == 4'd7) begin
      vote7 <= rxs;
    end
    if (tick && s_cnt == 4'd8) begin
      vote8 <= rxs;
    end
    if (shift_en) begin
      shift <= {bit_now, shift[7:1]};
    end
  end

`ifdef UART_RX_PARITY_EN
  // Parity check result, consumed at the stop-bit decision
  always_ff @(posedge sysclk) begin
    if (reset) begin
      parity_ok <= 1'b1;
    end else if (par_store) begin
      parity_ok <= (bit_now == ((^shift) ^ PARITY_BIT));
    end
  end
`else
  assign parity_ok = 1'b1;
  logic unused_parity_cfg;
  assign unused_parity_cfg = (PARITY_ODD != 0);
`endif

  // Holding register: load, ack handshake and sticky error flags (set beats ack)
  always_ff @(posedge sysclk) begin
    if (reset) begin
      rx_data_q   <= 8'h00;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      if (load_p1) begin
        if (!rx_valid_q || rx_if.rx_ack) begin
          rx_data_q  <= shift;
          rx_valid_q <= 1'b1;
        end
      end else if (rx_if.rx_ack) begin
        rx_valid_q <= 1'b0;
      end
      frame_err_q <= ferr_set | (frame_err_q & ~rx_if.rx_ack);
      overrun_q   <= (load_p1 & rx_valid_q & ~rx_if.rx_ack) | (overrun_q & ~rx_if.rx_ack);
    end
  end

  assign rx_if.rx_data   = rx_data_q;
  assign rx_if.rx_valid  = rx_valid_q;
  assign rx_if.frame_err = frame_err_q;
  assign rx_if.overrun   = overrun_q;
  assign rx_if.rx_busy   = rx_busy_q;

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed testbench for uart_rx_frame at CLK_HZ=1.6 MHz, BAUD=10k (160 clk per bit).
// Parity scenario compiled only when UART_RX_PARITY_EN is defined.
module tb_uart_rx_frame;

  localparam int CLK_HZ = 1_600_000;
  localparam int BAUD   = 10_000;
  localparam int BIT    = 160;
  localparam int PO     = 0;
`ifdef UART_RX_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif
  localparam int LAT_LO = (FRAME_BITS - 1) * BIT + 80;
  localparam int LAT_HI = (FRAME_BITS - 1) * BIT + 130;

  logic sysclk = 1'b0;
  logic reset;
  int   tests = 0;
  int   fails = 0;

  uart_rx_frame_if bus();

  uart_rx_frame #(
    .CLK_HZ     (CLK_HZ),
    .BAUD       (BAUD),
    .PARITY_ODD (PO)
  ) dut (
    .sysclk (sysclk),
    .reset  (reset),
    .rx_if  (bus)
  );

  always #5 sysclk = ~sysclk;

  function automatic logic par_of(input logic [7:0] b);
    return (^b) ^ (PO != 0);
  endfunction

  // Drives one frame starting at the current negedge; leaves the line at stop_v
  task automatic send_frame(input logic [7:0] b, input logic stop_v, input logic par_v);
    bus.uart_rx = 1'b0;
    repeat (BIT) @(negedge sysclk);
    for (int i = 0; i < 8; i++) begin
      bus.uart_rx = b[i];
      repeat (BIT) @(negedge sysclk);
    end
`ifdef UART_RX_PARITY_EN
    bus.uart_rx = par_v;
    repeat (BIT) @(negedge sysclk);
`endif
    bus.uart_rx = stop_v;
    repeat (BIT) @(negedge sysclk);
  endtask

  task automatic pulse_ack();
    bus.rx_ack = 1'b1;
    @(negedge sysclk);
    bus.rx_ack = 1'b0;
    @(negedge sysclk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (4) @(negedge sysclk);
    tests++; if (bus.rx_data !== 8'h00) begin fails++; $display("FAIL reset_data: got %h want 00", bus.rx_data); end
    tests++; if (bus.rx_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", bus.rx_valid); end
    tests++; if (bus.frame_err !== 1'b0) begin fails++; $display("FAIL reset_ferr: got %b want 0", bus.frame_err); end
    tests++; if (bus.overrun !== 1'b0) begin fails++; $display("FAIL reset_ovr: got %b want 0", bus.overrun); end
    tests++; if (bus.rx_busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", bus.rx_busy); end
    reset = 1'b0;
    repeat (10) @(negedge sysclk);
  endtask

  task automatic test_basic();
    int  lat;
    bit  seen;
    lat  = 0;
    seen = 1'b0;
    fork
      send_frame(8'hA5, 1'b1, par_of(8'hA5));
      begin
        while (!seen && lat < 3000) begin
          @(negedge sysclk);
          lat++;
          if (bus.rx_valid === 1'b1) seen = 1'b1;
        end
      end
    join
    tests++; if (!seen || lat < LAT_LO || lat > LAT_HI) begin fails++; $display("FAIL basic_latency: got %0d clk (seen=%0d) want %0d..%0d", lat, seen, LAT_LO, LAT_HI); end
    tests++; if (bus.rx_data !== 8'hA5) begin fails++; $display("FAIL basic_data: got %h want a5", bus.rx_data); end
    tests++; if (bus.rx_valid !== 1'b1) begin fails++; $display("FAIL basic_valid: got %b want 1", bus.rx_valid); end
    tests++; if (bus.frame_err !== 1'b0) begin fails++; $display("FAIL basic_ferr: got %b want 0", bus.frame_err); end
    tests++; if (bus.overrun !== 1'b0) begin fails++; $display("FAIL basic_ovr: got %b want 0", bus.overrun); end
    pulse_ack();
    tests++; if (bus.rx_valid !== 1'b0) begin fails++; $display("FAIL basic_ack_valid: got %b want 0", bus.rx_valid); end
  endtask

  task automatic test_glitch();
    bus.uart_rx = 1'b0;
    repeat (20) @(negedge sysclk);
    tests++; if (bus.rx_busy !== 1'b1) begin fails++; $display("FAIL glitch_busy_during: got %b want 1", bus.rx_busy); end
    repeat (20) @(negedge sysclk);
    bus.uart_rx = 1'b1;
    repeat (200) @(negedge sysclk);
    tests++; if (bus.rx_busy !== 1'b0) begin fails++; $display("FAIL glitch_busy_after: got %b want 0", bus.rx_busy); end
    tests++; if (bus.rx_valid !== 1'b0) begin fails++; $display("FAIL glitch_valid: got %b want 0", bus.rx_valid); end
    tests++; if (bus.frame_err !== 1'b0) begin fails++; $display("FAIL glitch_ferr: got %b want 0", bus.frame_err); end
    tests++; if (bus.rx_data !== 8'hA5) begin fails++; $display("FAIL glitch_data: got %h want a5", bus.rx_data); end
  endtask

  task automatic test_break();
    send_frame(8'h3C, 1'b0, par_of(8'h3C));
    tests++; if (bus.frame_err !== 1'b1) begin fails++; $display("FAIL break_ferr: got %b want 1", bus.frame_err); end
    tests++; if (bus.rx_valid !== 1'b0) begin fails++; $display("FAIL break_valid: got %b want 0", bus.rx_valid); end
    tests++; if (bus.rx_busy !== 1'b1) begin fails++; $display("FAIL break_busy: got %b want 1", bus.rx_busy); end
    repeat (2000) @(negedge sysclk);
    tests++; if (bus.rx_valid !== 1'b0) begin fails++; $display("FAIL break_hold_valid: got %b want 0", bus.rx_valid); end
    tests++; if (bus.rx_busy !== 1'b1) begin fails++; $display("FAIL break_hold_busy: got %b want 1", bus.rx_busy); end
    bus.uart_rx = 1'b1;
    repeat (20) @(negedge sysclk);
    tests++; if (bus.rx_busy !== 1'b0) begin fails++; $display("FAIL break_release_busy: got %b want 0", bus.rx_busy); end
    send_frame(8'h11, 1'b1, par_of(8'h11));
    tests++; if (bus.rx_data !== 8'h11) begin fails++; $display("FAIL break_next_data: got %h want 11", bus.rx_data); end
    tests++; if (bus.rx_valid !== 1'b1) begin fails++; $display("FAIL break_next_valid: got %b want 1", bus.rx_valid); end
    tests++; if (bus.frame_err !== 1'b1) begin fails++; $display("FAIL break_sticky_ferr: got %b want 1", bus.frame_err); end
    pulse_ack();
    tests++; if (bus.frame_err !== 1'b0) begin fails++; $display("FAIL break_ack_ferr: got %b want 0", bus.frame_err); end
    tests++; if (bus.rx_valid !== 1'b0) begin fails++; $display("FAIL break_ack_valid: got %b want 0", bus.rx_valid); end
  endtask

  task automatic test_overrun();
    int n;
    send_frame(8'h01, 1'b1, par_of(8'h01));
    send_frame(8'h02, 1'b1, par_of(8'h02));
    tests++; if (bus.rx_data !== 8'h01) begin fails++; $display("FAIL ovr_data: got %h want 01", bus.rx_data); end
    tests++; if (bus.overrun !== 1'b1) begin fails++; $display("FAIL ovr_flag: got %b want 1", bus.overrun); end
    tests++; if (bus.rx_valid !== 1'b1) begin fails++; $display("FAIL ovr_valid: got %b want 1", bus.rx_valid); end
    pulse_ack();
    tests++; if (bus.overrun !== 1'b0) begin fails++; $display("FAIL ovr_ack_clear: got %b want 0", bus.overrun); end
    send_frame(8'h01, 1'b1, par_of(8'h01));
    n = 0;
    fork
      send_frame(8'h02, 1'b1, par_of(8'h02));
      begin
        while (bus.rx_busy !== 1'b1 && n < 3000) begin @(negedge sysclk); n++; end
        while (bus.rx_busy !== 1'b0 && n < 3000) begin @(negedge sysclk); n++; end
        tests++;
        if (n >= 3000) begin
          fails++;
          $display("FAIL ovr_ack_sync: got timeout after %0d clk want busy fall", n);
        end else begin
          bus.rx_ack = 1'b1;
          @(negedge sysclk);
          bus.rx_ack = 1'b0;
        end
      end
    join
    tests++; if (bus.rx_data !== 8'h02) begin fails++; $display("FAIL ovr_sameack_data: got %h want 02", bus.rx_data); end
    tests++; if (bus.rx_valid !== 1'b1) begin fails++; $display("FAIL ovr_sameack_valid: got %b want 1", bus.rx_valid); end
    tests++; if (bus.overrun !== 1'b0) begin fails++; $display("FAIL ovr_sameack_flag: got %b want 0", bus.overrun); end
  endtask

  task automatic test_reset_midframe();
    fork
      send_frame(8'hFF, 1'b1, par_of(8'hFF));
      begin
        repeat (5 * BIT + BIT / 2) @(negedge sysclk);
        reset = 1'b1;
        repeat (3) @(negedge sysclk);
        reset = 1'b0;
        @(negedge sysclk);
        tests++; if (bus.rx_valid !== 1'b0) begin fails++; $display("FAIL rstmid_valid: got %b want 0", bus.rx_valid); end
        tests++; if (bus.rx_data !== 8'h00) begin fails++; $display("FAIL rstmid_data: got %h want 00", bus.rx_data); end
        tests++; if (bus.rx_busy !== 1'b0) begin fails++; $display("FAIL rstmid_busy: got %b want 0", bus.rx_busy); end
      end
    join
    tests++; if (bus.rx_valid !== 1'b0) begin fails++; $display("FAIL rstmid_no_partial: got %b want 0", bus.rx_valid); end
    send_frame(8'h5A, 1'b1, par_of(8'h5A));
    tests++; if (bus.rx_data !== 8'h5A) begin fails++; $display("FAIL rstmid_next_data: got %h want 5a", bus.rx_data); end
    tests++; if (bus.rx_valid !== 1'b1) begin fails++; $display("FAIL rstmid_next_valid: got %b want 1", bus.rx_valid); end
    tests++; if (bus.frame_err !== 1'b0) begin fails++; $display("FAIL rstmid_ferr: got %b want 0", bus.frame_err); end
    tests++; if (bus.overrun !== 1'b0) begin fails++; $display("FAIL rstmid_ovr: got %b want 0", bus.overrun); end
    pulse_ack();
  endtask

`ifdef UART_RX_PARITY_EN
  task automatic test_parity();
    send_frame(8'h07, 1'b1, 1'b1);
    tests++; if (bus.rx_data !== 8'h07) begin fails++; $display("FAIL par_good_data: got %h want 07", bus.rx_data); end
    tests++; if (bus.rx_valid !== 1'b1) begin fails++; $display("FAIL par_good_valid: got %b want 1", bus.rx_valid); end
    tests++; if (bus.frame_err !== 1'b0) begin fails++; $display("FAIL par_good_ferr: got %b want 0", bus.frame_err); end
    pulse_ack();
    send_frame(8'h07, 1'b1, 1'b0);
    tests++; if (bus.frame_err !== 1'b1) begin fails++; $display("FAIL par_bad_ferr: got %b want 1", bus.frame_err); end
    tests++; if (bus.rx_valid !== 1'b0) begin fails++; $display("FAIL par_bad_valid: got %b want 0", bus.rx_valid); end
    pulse_ack();
  endtask
`endif

  initial begin
    reset       = 1'b1;
    bus.uart_rx = 1'b1;
    bus.rx_ack  = 1'b0;
    @(negedge sysclk);
    test_reset();
    test_basic();
    test_glitch();
    test_break();
    test_overrun();
    test_reset_midframe();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
